// File: rtl/zero_run_pkg.sv
// Shared types and default widths for the Zero program-core run controller.
// Build option: ZERO_RUN_BREAKPOINT_EN adds the instruction-pointer breakpoint.
package zero_run_pkg;

   localparam int MEM_W_DEF      = 12;
   localparam int IP_W_DEF       = 16;
   localparam int STEP_W_DEF     = 32;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STEP,
      ST_DONE,
      ST_PAUSE
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == ST_LOAD) || (s == ST_STEP) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/zero_run_fifo.sv
// Synchronous FIFO buffering the core's out-channel words.
// A push on a full FIFO succeeds only when a pop frees a slot in the same cycle.
module zero_run_fifo #(
   parameter int Width = 12,
   parameter int Depth = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(Depth));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/zero_run_controller.sv
// Counted-step sequencer for one Zero program core with out-channel FIFO.
// Build option: ZERO_RUN_BREAKPOINT_EN adds break_en/break_ip/resume/paused.
module zero_run_controller
   import zero_run_pkg::*;
#(
   parameter int MemoryElementWidth = MEM_W_DEF,
   parameter int IpWidth            = IP_W_DEF,
   parameter int StepWidth          = STEP_W_DEF,
   parameter int OutFifoDepth       = FIFO_DEPTH_DEF
) (
   input  logic                          clock,
   input  logic                          reset,
`ifdef ZERO_RUN_BREAKPOINT_EN
   input  logic                          break_en,
   input  logic [IpWidth-1:0]            break_ip,
   input  logic                          resume,
   output logic                          paused,
`endif
   input  logic                          start,
   input  logic [StepWidth-1:0]          step_limit,
   output logic                          busy,
   output logic                          done,
   output logic                          passed,
   output logic                          timeout,
   output logic [StepWidth-1:0]          steps,
   output logic                          overflow,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MemoryElementWidth-1:0] out_data,
   output logic                          core_run,
   output logic                          core_step,
   input  logic [IpWidth-1:0]            core_ip,
   input  logic                          core_finished,
   input  logic                          core_success,
   input  logic                          core_out_valid,
   input  logic [MemoryElementWidth-1:0] core_out_data
);

   state_t               state;
   logic [StepWidth-1:0] limit;
   logic                 start_ok;
   logic                 limit_hit;
   logic                 brk_hit;
   logic                 push_req;
   logic                 pop;
   logic                 full;
   logic                 empty;

   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
   assign limit_hit = (limit != '0) && (steps == limit);

`ifdef ZERO_RUN_BREAKPOINT_EN
   // After a resume the compare stays disarmed until one step has issued.
   logic skip;
   assign brk_hit = break_en && (core_ip == break_ip) && !skip;
   assign paused  = (state == ST_PAUSE);
`else
   logic unused;
   assign brk_hit = 1'b0;
   assign unused  = ^core_ip;
`endif

   assign core_step = (state == ST_STEP) && !core_finished
                    && !limit_hit && !brk_hit;
   assign core_run  = (state == ST_LOAD);
   assign busy      = is_busy(state);
   assign done      = (state == ST_DONE);

   assign push_req  = core_out_valid && (state != ST_IDLE);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   zero_run_fifo #(
      .Width (MemoryElementWidth),
      .Depth (OutFifoDepth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (start_ok),
      .push  (push_req),
      .pop   (pop),
      .wdata (core_out_data),
      .rdata (out_data),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         limit    <= '0;
         steps    <= '0;
         passed   <= 1'b0;
         timeout  <= 1'b0;
         overflow <= 1'b0;
`ifdef ZERO_RUN_BREAKPOINT_EN
         skip     <= 1'b0;
`endif
      end else begin
         if (push_req && full && !pop) begin
            overflow <= 1'b1;
         end
         if (core_step && (steps != '1)) begin
            steps <= steps + StepWidth'(1);
         end
`ifdef ZERO_RUN_BREAKPOINT_EN
         if (core_step) begin
            skip <= 1'b0;
         end
`endif
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_LOAD;
                  limit    <= step_limit;
                  steps    <= '0;
                  passed   <= 1'b0;
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
`ifdef ZERO_RUN_BREAKPOINT_EN
                  skip     <= 1'b0;
`endif
               end
            end
            ST_LOAD: state <= ST_STEP;
            ST_STEP: begin
               if (core_finished) begin
                  state   <= ST_DONE;
                  passed  <= core_success;
                  timeout <= 1'b0;
               end else if (limit_hit) begin
                  state   <= ST_DONE;
                  passed  <= 1'b0;
                  timeout <= 1'b1;
               end else if (brk_hit) begin
                  state <= ST_PAUSE;
               end
            end
`ifdef ZERO_RUN_BREAKPOINT_EN
            ST_PAUSE: begin
               if (resume) begin
                  state <= ST_STEP;
                  skip  <= 1'b1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zero_run_controller.sv
// Bench for zero_run_controller: directed runs, random runs and FIFO traffic.
// The breakpoint scenario is exercised when ZERO_RUN_BREAKPOINT_EN is defined.
module tb_zero_run_controller;

   localparam int MW = 12;
   localparam int IW = 16;
   localparam int SW = 32;
   localparam int D  = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [SW-1:0] step_limit = '0;
   logic          busy, done, passed, timeout, overflow;
   logic [SW-1:0] steps;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [MW-1:0] out_data;
   logic          core_run, core_step;
   logic [IW-1:0] core_ip = '0;
   logic          core_finished = 1'b0;
   logic          core_success = 1'b0;
   logic          core_out_valid = 1'b0;
   logic [MW-1:0] core_out_data = '0;
`ifdef ZERO_RUN_BREAKPOINT_EN
   logic          break_en = 1'b0;
   logic [IW-1:0] break_ip = '0;
   logic          resume = 1'b0;
   logic          paused;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   zero_run_controller #(
      .MemoryElementWidth (MW),
      .IpWidth            (IW),
      .StepWidth          (SW),
      .OutFifoDepth       (D)
   ) dut (
      .clock          (clock),
      .reset          (reset),
`ifdef ZERO_RUN_BREAKPOINT_EN
      .break_en       (break_en),
      .break_ip       (break_ip),
      .resume         (resume),
      .paused         (paused),
`endif
      .start          (start),
      .step_limit     (step_limit),
      .busy           (busy),
      .done           (done),
      .passed         (passed),
      .timeout        (timeout),
      .steps          (steps),
      .overflow       (overflow),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .core_run       (core_run),
      .core_step      (core_step),
      .core_ip        (core_ip),
      .core_finished  (core_finished),
      .core_success   (core_success),
      .core_out_valid (core_out_valid),
      .core_out_data  (core_out_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Core that finishes once f steps have been issued; reference result is
   // derived from the run rules: finish beats an exhausted budget.
   task automatic do_run(input int f, input int l, input bit succ,
                         input string tag);
      int  cnt = 0;
      int  nruns = 0;
      int  run_idx = -1;
      int  first_step = -1;
      int  done_idx = -1;
      bit  exp_to;
      int  exp_steps;
      exp_to    = (l != 0) && (l < f);
      exp_steps = exp_to ? l : f;
      @(negedge clock);
      start = 1'b1;
      step_limit = SW'(l);
      core_success = succ;
      core_finished = 1'b0;
      core_ip = '0;
      for (int idx = 1; idx < 300; idx++) begin
         @(negedge clock);
         start = 1'b0;
         core_finished = (cnt >= f);
         core_ip = IW'(cnt);
         #1;
         if (core_run) begin
            nruns++;
            if (run_idx < 0) run_idx = idx;
         end
         if (core_step) begin
            cnt++;
            if (first_step < 0) first_step = idx;
         end
         if (done) begin
            done_idx = idx;
            break;
         end
      end
      chk({tag, ".run_idx"}, run_idx, 1);
      chk({tag, ".run_cnt"}, nruns, 1);
      chk({tag, ".first_step"}, first_step, (exp_steps > 0) ? 2 : -1);
      chk({tag, ".done_idx"}, done_idx, exp_steps + 3);
      chk({tag, ".steps"}, steps, exp_steps);
      chk({tag, ".step_pulses"}, cnt, exp_steps);
      chk({tag, ".passed"}, passed, succ && !exp_to);
      chk({tag, ".timeout"}, timeout, exp_to);
      chk({tag, ".busy"}, busy, 0);
      core_finished = 1'b0;
   endtask

   initial begin
      logic [MW-1:0] q[$];
      bit            ovf;
      bit            p, r, popped;
      logic [MW-1:0] w;

      repeat (2) @(negedge clock);
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.passed", passed, 0);
      chk("rst.timeout", timeout, 0);
      chk("rst.steps", steps, 0);
      chk("rst.overflow", overflow, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.core_run", core_run, 0);
      chk("rst.core_step", core_step, 0);
      @(negedge clock);
      reset = 1'b0;

      do_run(6, 0, 1'b1, "finish6");
      repeat (3) @(negedge clock);
      #1;
      chk("hold.done", done, 1);
      chk("hold.steps", steps, 6);
      do_run(1000, 10, 1'b1, "limit10");
      do_run(5, 5, 1'b1, "tie_pass");
      do_run(5, 5, 1'b0, "tie_fail");
      do_run(0, 0, 1'b1, "finish0");

      // Overflow: ten words into an eight-deep FIFO with no reader.
      out_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         core_out_valid = 1'b1;
         core_out_data = MW'(i);
      end
      @(negedge clock);
      core_out_valid = 1'b0;
      #1;
      chk("ovf.flag", overflow, 1);
      chk("ovf.valid", out_valid, 1);
      for (int i = 1; i <= D; i++) begin
         out_ready = 1'b1;
         #1;
         chk("drain.valid", out_valid, 1);
         chk("drain.data", out_data, i);
         @(negedge clock);
      end
      out_ready = 1'b0;
      #1;
      chk("drain.empty", out_valid, 0);

      do_run(3, 0, 1'b1, "clear");
      chk("clear.overflow", overflow, 0);

      for (int k = 0; k < 6; k++) begin
         int f;
         int l;
         f = int'($urandom_range(0, 15));
         l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
         do_run(f, l, 1'(($urandom_range(0, 1))), $sformatf("rnd%0d", k));
      end

      // Random push/pop traffic against a queue model, in DONE.
      ovf = 1'b0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clock);
         p = ($urandom_range(0, 9) < 6);
         r = ($urandom_range(0, 9) < 4);
         w = MW'($urandom);
         core_out_valid = p;
         core_out_data = w;
         out_ready = r;
         #1;
         chk("rfifo.valid", out_valid, q.size() != 0);
         if (q.size() != 0) chk("rfifo.data", out_data, q[0]);
         popped = r && (q.size() != 0);
         if (p && q.size() == D && !popped) ovf = 1'b1;
         if (popped) void'(q.pop_front());
         if (p && q.size() < D) q.push_back(w);
      end
      @(negedge clock);
      core_out_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rfifo.overflow", overflow, ovf);

      // Reset in the middle of a run that would never finish.
      @(negedge clock);
      start = 1'b1;
      step_limit = '0;
      core_finished = 1'b0;
      @(negedge clock);
      start = 1'b0;
      core_out_valid = 1'b1;
      core_out_data = 12'h5a5;
      @(negedge clock);
      core_out_valid = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("mid.busy", busy, 1);
      chk("mid.out_valid", out_valid, 1);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("mrst.busy", busy, 0);
      chk("mrst.done", done, 0);
      chk("mrst.steps", steps, 0);
      chk("mrst.out_valid", out_valid, 0);
      chk("mrst.core_step", core_step, 0);
      chk("mrst.core_run", core_run, 0);
      chk("mrst.passed", passed, 0);
      chk("mrst.timeout", timeout, 0);
      reset = 1'b0;
      do_run(3, 0, 1'b1, "after_rst");

`ifdef ZERO_RUN_BREAKPOINT_EN
      begin
         int cnt = 0;
         int hit = 0;
         break_en = 1'b1;
         break_ip = 16'd3;
         @(negedge clock);
         start = 1'b1;
         step_limit = '0;
         core_success = 1'b1;
         for (int idx = 0; idx < 100; idx++) begin
            @(negedge clock);
            start = 1'b0;
            core_finished = (cnt >= 6);
            core_ip = IW'(cnt);
            #1;
            if (core_step) cnt++;
            if (paused) begin
               hit = 1;
               break;
            end
         end
         chk("brk.hit", hit, 1);
         chk("brk.ip", core_ip, 3);
         chk("brk.core_step", core_step, 0);
         repeat (3) @(negedge clock);
         #1;
         chk("brk.hold", paused, 1);
         chk("brk.steps", steps, 3);
         resume = 1'b1;
         @(negedge clock);
         resume = 1'b0;
         for (int idx = 0; idx < 100; idx++) begin
            core_finished = (cnt >= 6);
            core_ip = IW'(cnt);
            #1;
            if (core_step) cnt++;
            if (done) break;
            @(negedge clock);
         end
         chk("brk.done", done, 1);
         chk("brk.passed", passed, 1);
         chk("brk.final_steps", steps, 6);
         break_en = 1'b0;
         core_finished = 1'b0;
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
